// File: rtl/qpu_qiu_event_scheduler.sv
// Timed issue queue: buffers QIU events and releases each one when the system time reaches its timestamp.
// Owns the system time counter and flags any event that leaves after its timestamp.
`ifndef QPU_EVENT_WIRE_WIDTH
`define QPU_EVENT_WIRE_WIDTH 32
`endif
`ifndef QPU_EVENT_NUM
`define QPU_EVENT_NUM 8
`endif
`ifndef QPU_TIME_WIDTH
`define QPU_TIME_WIDTH 32
`endif

module qpu_qiu_event_scheduler #(
  parameter int EVENT_WIRE_WIDTH = `QPU_EVENT_WIRE_WIDTH,
  parameter int EVENT_NUM        = `QPU_EVENT_NUM,
  parameter int TIME_WIDTH       = `QPU_TIME_WIDTH,
  parameter int DEPTH            = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        sched_i_valid,
  output logic                        sched_i_ready,
  input  logic [EVENT_WIRE_WIDTH-1:0] sched_i_edata,
  input  logic [EVENT_NUM-1:0]        sched_i_oprand,
  input  logic [TIME_WIDTH-1:0]       sched_i_tdata,
  output logic                        sched_o_valid,
  input  logic                        sched_o_ready,
  output logic [EVENT_WIRE_WIDTH-1:0] sched_o_edata,
  output logic [EVENT_NUM-1:0]        sched_o_oprand,
  output logic [TIME_WIDTH-1:0]       sched_o_time,
  input  logic                        sched_i_start,
  input  logic                        sched_i_stop,
  input  logic                        sched_i_flush,
  output logic                        sched_o_late,
  input  logic                        sched_i_late_clr,
  output logic                        sched_o_running,
  output logic [$clog2(DEPTH):0]      sched_o_count
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic {IDLE, RUN} state_t;

  state_t                state_q, state_d;
  logic [TIME_WIDTH-1:0] time_q, time_d;
  logic [AW-1:0]         rd_ptr_q, wr_ptr_q;
  logic [AW:0]           count_q;
  logic                  late_q;

  logic [EVENT_WIRE_WIDTH-1:0] edata_mem_q  [DEPTH];
  logic [EVENT_NUM-1:0]        oprand_mem_q [DEPTH];
  logic [TIME_WIDTH-1:0]       tdata_mem_q  [DEPTH];

  logic                  full, empty, due, push, pop;
  logic [TIME_WIDTH-1:0] diff;

  assign full  = (count_q == (AW+1)'(DEPTH));
  assign empty = (count_q == '0);

  // Modular distance to the head timestamp; a negative distance means the event is already past due.
  assign diff = tdata_mem_q[rd_ptr_q] - time_q;
  assign due  = (diff == '0) || diff[TIME_WIDTH-1];

  assign sched_i_ready   = !full && !sched_i_flush;
  assign sched_o_valid   = (state_q == RUN) && !empty && due && !sched_i_flush;
  assign sched_o_edata   = edata_mem_q[rd_ptr_q];
  assign sched_o_oprand  = oprand_mem_q[rd_ptr_q];
  assign sched_o_time    = time_q;
  assign sched_o_late    = late_q;
  assign sched_o_running = (state_q == RUN);
  assign sched_o_count   = count_q;

  assign push = sched_i_valid && sched_i_ready;
  assign pop  = sched_o_valid && sched_o_ready;

  // Stop overrides start: it freezes the counter and suppresses the clear.
  always_comb begin
    state_d = state_q;
    time_d  = time_q;
    if (sched_i_stop) begin
      state_d = IDLE;
    end else if (sched_i_start) begin
      state_d = RUN;
    end
    if (sched_i_start && !sched_i_stop) begin
      time_d = '0;
    end else if (state_q == RUN && !sched_i_stop) begin
      time_d = time_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      time_q  <= '0;
    end else begin
      state_q <= state_d;
      time_q  <= time_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        edata_mem_q[i]  <= '0;
        oprand_mem_q[i] <= '0;
        tdata_mem_q[i]  <= '0;
      end
    end else if (sched_i_flush) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        edata_mem_q[wr_ptr_q]  <= sched_i_edata;
        oprand_mem_q[wr_ptr_q] <= sched_i_oprand;
        tdata_mem_q[wr_ptr_q]  <= sched_i_tdata;
        wr_ptr_q               <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      if (push && !pop) begin
        count_q <= count_q + 1'b1;
      end else if (pop && !push) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      late_q <= 1'b0;
    end else if (pop && diff != '0) begin
      late_q <= 1'b1;
    end else if (sched_i_late_clr) begin
      late_q <= 1'b0;
    end
  end

endmodule
